// File: rtl/mem_stage_pkg.sv
// Shared op codes, FSM states and request record for the memory-access stage.
package mem_stage_pkg;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  op;
    logic [4:0]  rd;
  } mem_req_t;

  function automatic logic is_mem(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return a[0];
      MEM_OP_LW, MEM_OP_SW:             return a != 2'b00;
      default:                          return 1'b0;
    endcase
  endfunction

  // Byte enables and lane-replicated data so memory can write any lane directly.
  function automatic mem_req_t build_req(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] sd, input logic [4:0] rd);
    mem_req_t r;
    r.waddr = a[31:2];
    r.lane  = a[1:0];
    r.op    = op;
    r.rd    = rd;
    case (op)
      MEM_OP_SB: begin r.be = 4'b0001 << a[1:0]; r.wdata = {4{sd[7:0]}};  end
      MEM_OP_SH: begin r.be = 4'b0011 << a[1:0]; r.wdata = {2{sd[15:0]}}; end
      MEM_OP_SW: begin r.be = 4'b1111;           r.wdata = sd;            end
      default:   begin r.be = 4'b1111;           r.wdata = '0;            end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half lane of read data and sign/zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [3:0]  op,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_OP_LB:  data = {{24{b[7]}}, b};
      MEM_OP_LBU: data = {24'd0, b};
      MEM_OP_LH:  data = {{16{h[15]}}, h};
      MEM_OP_LHU: data = {16'd0, h};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU pass-through plus a req/ack load/store FSM
// that stalls upstream stages until the access completes.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ans_i,
  input  logic               write_enable_i,
  input  logic [4:0]         write_addr_i,
  input  logic [3:0]         mem_op_i,
  input  logic [31:0]        store_data_i,
  output logic [31:0]        ans_o,
  output logic               write_enable_o,
  output logic [4:0]         write_addr_o,
  output logic               stall_req_o,
  output logic               addr_error_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [31:0]        dmem_wdata_o,
  input  logic [31:0]        dmem_rdata_i,
  input  logic               dmem_ack_i
);

  state_e      state;
  mem_req_t    req_q;
  logic [31:0] load_q;
  logic [31:0] load_val;
  logic        op_mem;
  logic        op_mis;

  // Widen first so the word address zero-extends or truncates for any DMEM_AW.
  logic [DMEM_AW+29:0] addr_ext;
  assign addr_ext = {{DMEM_AW{1'b0}}, req_q.waddr};

  assign op_mem = is_mem(mem_op_i);
  assign op_mis = misaligned(mem_op_i, ans_i[1:0]);

  mem_load_align u_align (
    .rdata (dmem_rdata_i),
    .a     (req_q.lane),
    .op    (req_q.op),
    .data  (load_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      req_q  <= '0;
      load_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (op_mem && !op_mis) begin
          req_q <= build_req(mem_op_i, ans_i, store_data_i, write_addr_i);
          state <= ST_WAIT;
        end
        ST_WAIT: if (dmem_ack_i) begin
          if (is_load(req_q.op)) load_q <= load_val;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ans_o          = '0;
    write_enable_o = 1'b0;
    write_addr_o   = '0;
    stall_req_o    = 1'b0;
    addr_error_o   = 1'b0;
    dmem_req_o     = 1'b0;
    dmem_we_o      = 1'b0;
    dmem_addr_o    = '0;
    dmem_be_o      = '0;
    dmem_wdata_o   = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          ans_o        = ans_i;
          write_addr_o = write_addr_i;
          if (!op_mem)     write_enable_o = write_enable_i;
          else if (op_mis) addr_error_o   = 1'b1;
          else             stall_req_o    = 1'b1;
        end
        ST_WAIT: begin
          stall_req_o  = 1'b1;
          dmem_req_o   = 1'b1;
          dmem_we_o    = is_store(req_q.op);
          dmem_addr_o  = addr_ext[DMEM_AW-1:0];
          dmem_be_o    = req_q.be;
          dmem_wdata_o = req_q.wdata;
        end
        ST_DONE: begin
          ans_o        = load_q;
          write_addr_o = req_q.rd;
          write_enable_o = is_load(req_q.op);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a responding memory model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ans_i = '0;
  logic        write_enable_i = 1'b0;
  logic [4:0]  write_addr_i = '0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] store_data_i = '0;
  logic [31:0] ans_o;
  logic        write_enable_o;
  logic [4:0]  write_addr_o;
  logic        stall_req_o;
  logic        addr_error_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_AW(32)) dut (
    .clk(clk), .rst(rst), .ans_i(ans_i), .write_enable_i(write_enable_i),
    .write_addr_i(write_addr_i), .mem_op_i(mem_op_i), .store_data_i(store_data_i),
    .ans_o(ans_o), .write_enable_o(write_enable_o), .write_addr_o(write_addr_o),
    .stall_req_o(stall_req_o), .addr_error_o(addr_error_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i)
  );

  typedef struct {
    logic [31:0] ans;
    logic        we;
    logic [4:0]  wa;
    logic        aerr;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mreq_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    live = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk32({tag, "_ans"}, ans_o, 32'd0);
    chk1({tag, "_we"}, write_enable_o, 1'b0);
    chk32({tag, "_wa"}, 32'(write_addr_o), 32'd0);
    chk1({tag, "_stall"}, stall_req_o, 1'b0);
    chk1({tag, "_aerr"}, addr_error_o, 1'b0);
    chk1({tag, "_req"}, dmem_req_o, 1'b0);
    chk1({tag, "_dwe"}, dmem_we_o, 1'b0);
    chk32({tag, "_daddr"}, dmem_addr_o, 32'd0);
    chk32({tag, "_be"}, 32'(dmem_be_o), 32'd0);
    chk32({tag, "_wdata"}, dmem_wdata_o, 32'd0);
  endtask

  // Reference model: derive the retire record and memory request from the op rules.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic wei, input logic [4:0] wa, input int delay,
                       input logic [31:0] rdata);
    exp_t  e;
    mreq_t m;
    int    off;
    int    v;
    bit    is_m;
    bit    mis;
    int    n;
    is_m = (op >= 1) && (op <= 8);
    mis  = ((op == 3 || op == 4 || op == 7) && a[0]) || ((op == 5 || op == 8) && a[1:0] != 2'b00);
    off  = int'(a[1:0]);
    e.ans = a; e.we = is_m ? 1'b0 : wei; e.wa = wa; e.aerr = is_m && mis; e.stalls = 0;
    m.addr = a[31:2]; m.we = (op >= 6); m.be = 4'd0; m.wdata = 32'd0;
    m.delay = delay; m.rdata = rdata;
    if (is_m && !mis) begin
      e.stalls = 2 + delay;
      v = int'(rdata >> (8 * off));
      case (op)
        1: begin e.ans = ((v & 255) >= 128) ? 32'((v & 255) - 256) : 32'(v & 255); e.we = 1'b1; end
        2: begin e.ans = 32'(v & 255); e.we = 1'b1; end
        3: begin e.ans = ((v & 65535) >= 32768) ? 32'((v & 65535) - 65536) : 32'(v & 65535); e.we = 1'b1; end
        4: begin e.ans = 32'(v & 65535); e.we = 1'b1; end
        5: begin e.ans = rdata; e.we = 1'b1; end
        6: begin m.be = 4'(1 << off); m.wdata = (sd & 32'hFF) * 32'h0101_0101; end
        7: begin m.be = 4'(3 << off); m.wdata = (sd & 32'hFFFF) * 32'h0001_0001; end
        default: begin m.be = 4'hF; m.wdata = sd; end
      endcase
      mreq_q.push_back(m);
    end
    exp_q.push_back(e);
    mem_op_i = op; ans_i = a; store_data_i = sd; write_enable_i = wei; write_addr_i = wa;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!stall_req_o) break;
    end
    if (n == 100) begin
      checks++; errors++;
      $display("FAIL stall_timeout actual=stuck expected=release op=%0d", op);
    end
    @(posedge clk); #1;
  endtask

  // Retire monitor: every non-stalled cycle hands one instruction to MEM/WB.
  initial begin
    int   st;
    exp_t e;
    st = 0;
    forever begin
      @(negedge clk);
      if (rst || !live) st = 0;
      else if (stall_req_o) begin
        st++;
        chk1("bubble_we", write_enable_o, 1'b0);
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_retire actual=retire expected=none");
      end else begin
        e = exp_q.pop_front();
        chk1("addr_error", addr_error_o, e.aerr);
        chk1("wb_we", write_enable_o, e.we);
        if (e.we) begin
          chk32("wb_ans", ans_o, e.ans);
          chk32("wb_addr", 32'(write_addr_o), 32'(e.wa));
        end
        chk32("stall_cycles", st, e.stalls);
        st = 0;
      end
    end
  end

  // Memory responder: checks request fields every WAIT cycle and acks after the chosen delay.
  initial begin
    mreq_t m;
    bit    active;
    int    cnt;
    active = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0; dmem_ack_i = 1'b0;
      end else if (dmem_req_o) begin
        if (!active && mreq_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_req actual=req expected=idle");
          dmem_ack_i = 1'b1;
        end else begin
          if (!active) begin m = mreq_q.pop_front(); active = 1'b1; cnt = 0; end
          chk32("dmem_addr", dmem_addr_o, {2'b00, m.addr});
          chk1("dmem_we", dmem_we_o, m.we);
          if (m.we) begin
            chk32("dmem_be", 32'(dmem_be_o), 32'(m.be));
            chk32("dmem_wdata", dmem_wdata_o, m.wdata);
          end
          if (cnt == m.delay) begin
            dmem_ack_i = 1'b1; dmem_rdata_i = m.rdata; active = 1'b0;
          end else begin
            dmem_ack_i = 1'b0; dmem_rdata_i = $urandom; cnt++;
          end
        end
      end else begin
        chk1("dmem_we_idle", dmem_we_o, 1'b0);
        dmem_ack_i = 1'($urandom_range(0, 1));
        dmem_rdata_i = $urandom;
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    mreq_t       m;
    ans_i = 32'h1234_5678; write_enable_i = 1'b1; write_addr_i = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; live = 1'b1;

    issue(4'd0, 32'h1234_5678, 32'd0, 1'b1, 5'd5, 0, 32'd0);
    issue(4'd1, 32'h0000_0103, 32'd0, 1'b1, 5'd7, 0, 32'h80FF_0000);
    issue(4'd7, 32'h0000_0202, 32'hAAAA_BEEF, 1'b1, 5'd9, 2, 32'd0);
    issue(4'd5, 32'h0000_0101, 32'd0, 1'b1, 5'd3, 0, 32'd0);
    issue(4'd2, 32'h0000_0401, 32'd0, 1'b1, 5'd11, 1, 32'h1234_F5C0);
    issue(4'd8, 32'h0000_0300, 32'hDEAD_BEEF, 1'b0, 5'd0, 0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(op, a, $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 3), $urandom);
    end

    // Abandon a load in its second WAIT cycle with a reset.
    live = 1'b0;
    m.addr = 30'h10; m.we = 1'b0; m.be = 4'd0; m.wdata = 32'd0; m.delay = 10; m.rdata = 32'd0;
    mreq_q.push_back(m);
    mem_op_i = 4'd5; ans_i = 32'h0000_0040; write_addr_i = 5'd4; write_enable_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("pre_rst_req", dmem_req_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("in_rst");
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = 4'd0; ans_i = 32'd0; write_addr_i = 5'd0; write_enable_i = 1'b0;
    @(negedge clk);
    chk_all_zero("post_rst");
    @(posedge clk); #1;
    live = 1'b1;
    issue(4'd0, 32'hCAFE_F00D, 32'd0, 1'b1, 5'd17, 0, 32'd0);
    live = 1'b0;
    chk32("exp_q_drained", exp_q.size(), 32'd0);
    chk32("mreq_q_drained", mreq_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register. Passes ALU results straight through. Executes byte/half/word loads and stores against the data memory over a req/ack handshake, and holds the pipeline with `stall_req_o` until the access completes.

## Interface
Parameters:
- `DMEM_AW`, default 32: data-memory address width. `dmem_addr_o` carries the word address `ans_i[31:2]`, zero-extended or truncated to this width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high (`rst_enable` = 1).
- `ans_i` in 32 (`reg_bus`): ALU result, or effective address for memory ops.
- `write_enable_i` in 1: register writeback request from EX.
- `write_addr_i` in 5 (`reg_addr_bus`): destination register.
- `mem_op_i` in 4: memory operation code; see Structure.
- `store_data_i` in 32: rt value for stores.
- `ans_o` in/out: out 32: writeback data to MEM/WB.
- `write_enable_o` out 1: writeback enable.
- `write_addr_o` out 5: writeback register.
- `stall_req_o` out 1: freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB.
- `addr_error_o` out 1: misaligned-access flag, one cycle.
- `dmem_req_o` out 1: memory request.
- `dmem_we_o` out 1: 1 = write.
- `dmem_addr_o` out `DMEM_AW`: word address.
- `dmem_be_o` out 4: byte enables; bit n = byte lane n (little-endian).
- `dmem_wdata_o` out 32: store data, lane-replicated.
- `dmem_rdata_i` in 32: read data; valid when `dmem_ack_i` = 1.
- `dmem_ack_i` in 1: completes the request in the same cycle.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset → IDLE.
- While `rst` = 1, all outputs are 0.
- **IDLE, non-memory op** (code 0 or undefined 9–15):
  - `ans_o`/`write_enable_o`/`write_addr_o` = inputs, combinationally.
  - `stall_req_o` = 0; stay in IDLE.
- **IDLE, aligned memory op:**
  - `stall_req_o` = 1, `write_enable_o` = 0.
  - Latch address, `be`, `wdata`, op, `write_addr`; go to WAIT.
- **IDLE, misaligned op** (halfword with `ans_i[0]` = 1; word with `ans_i[1:0]` ≠ 0):
  - `addr_error_o` = 1, `write_enable_o` = 0, no request, no stall; stay in IDLE.
- **WAIT:**
  - `dmem_req_o` = 1 with the latched fields; `stall_req_o` = 1.
  - On `dmem_ack_i`: capture the aligned/extended load value (stores capture nothing); go to DONE.
  - No ack: hold all request fields stable indefinitely.
- **DONE:**
  - `stall_req_o` = 0.
  - Loads: `ans_o` = captured value, `write_enable_o` = 1, `write_addr_o` = latched.
  - Stores: `write_enable_o` = 0.
  - Next state IDLE; EX/MEM advances on this edge.
- **Stores:**
  - SB: `be` = 0001 << `a[1:0]`, wdata = byte ×4.
  - SH: `be` = 0011 << `a[1:0]`, wdata = half ×2.
  - SW: `be` = 1111.
- **Loads:** lane selected by `a[1:0]`; LB/LH sign-extend, LBU/LHU zero-extend.
- `dmem_we_o` = 1 only for SB/SH/SW while `dmem_req_o` = 1.

## Timing
- Non-memory op: 0 added cycles.
- Memory op with ack in the first WAIT cycle: 3 cycles in the stage (IDLE, WAIT, DONE), i.e. 2 stall cycles. Each extra ack-wait cycle adds one stall cycle.
- `dmem_req_o` falls in the cycle after ack. A new request needs at least one IDLE cycle in between.
- Reset mid-WAIT: `dmem_req_o` drops in the cycle after `rst` is sampled. The outstanding access is abandoned and memory must tolerate this.
- Ack outside WAIT is ignored.

## Structure
- `defines.vh` gains:
  - `mem_op_bus` [3:0].
  - Op codes: `mem_op_none` 0, `mem_op_lb` 1, `mem_op_lbu` 2, `mem_op_lh` 3, `mem_op_lhu` 4, `mem_op_lw` 5, `mem_op_sb` 6, `mem_op_sh` 7, `mem_op_sw` 8.
  - FSM state encodings.
- One combinational sub-module, `mem_load_align`: inputs `rdata`, `a[1:0]`, op; output the extended 32-bit value.

## Test plan
- ALU op: `ans_i` = 0x12345678, `write_enable_i` = 1, addr 5 → same cycle: `ans_o` = 0x12345678, we = 1, addr 5, no stall.
- LB at 0x103, rdata = 0x80FF_0000, ack on first WAIT → `stall_req_o` high 2 cycles; DONE: `ans_o` = 0xFFFFFF80, we = 1.
- SH at 0x202, `store_data_i` = 0xAAAA_BEEF, ack after 3 WAIT cycles:
  - fields held stable throughout; `be` = 1100, wdata = 0xBEEFBEEF, `dmem_addr_o` = 0x80;
  - stall lasts 4 cycles; we = 0.
- LW at 0x101 → `addr_error_o` = 1 for one cycle; no `dmem_req_o`; `write_enable_o` = 0.
- `rst` asserted in the 2nd WAIT cycle → next cycle: all outputs 0, state IDLE; a following ALU op passes through normally.
